// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP code encoder: neighbour count, rotator
// states and the rotation / transition-count helpers.
package lbp_pkg;

  localparam int NEIGH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    OUT  = 2'd2
  } rot_state_t;

  // Circular right rotation of an 8-bit code by n positions.
  function automatic logic [7:0] rotr8(input logic [7:0] code, input logic [2:0] n);
    logic [15:0] dbl;
    dbl = {code, code} >> n;
    return dbl[7:0];
  endfunction

  // Number of circular 0/1 transitions around the 8-bit code.
  function automatic logic [3:0] lbp_transitions(input logic [7:0] code);
    logic [7:0] diff;
    logic [3:0] cnt;
    diff = code ^ {code[6:0], code[7]};
    cnt  = 4'd0;
    for (int i = 0; i < NEIGH; i++) begin
      cnt = cnt + {3'b000, diff[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lbp_min_rotator.sv
// Rotation-invariant reducer: walks all eight rotations of a raw LBP code and
// emits the numerically smallest one with a one-cycle done pulse.
module lbp_min_rotator
  import lbp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] raw_code,
  input  logic       raw_uniform,
  output logic       idle,
  output logic [7:0] code,
  output logic       uniform,
  output logic       done
);

  rot_state_t state_reg, state_next;
  logic [2:0] cnt_reg;
  logic [7:0] raw_reg;
  logic [7:0] min_reg;
  logic       uni_reg;
  logic [7:0] code_reg;
  logic       uniform_reg;
  logic       done_reg;
  logic [7:0] rot_cand;

  always_comb begin
    state_next = state_reg;
    rot_cand   = rotr8(raw_reg, cnt_reg);
    case (state_reg)
      IDLE:    if (start) state_next = ROT;
      ROT:     if (cnt_reg == 3'd7) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      raw_reg     <= 8'd0;
      min_reg     <= 8'd0;
      uni_reg     <= 1'b0;
      code_reg    <= 8'd0;
      uniform_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            raw_reg <= raw_code;
            min_reg <= raw_code;
            uni_reg <= raw_uniform;
            cnt_reg <= 3'd1;
          end
        end
        ROT: begin
          if (rot_cand < min_reg) min_reg <= rot_cand;
          cnt_reg <= cnt_reg + 3'd1;
        end
        OUT: begin
          code_reg    <= min_reg;
          uniform_reg <= uni_reg;
          done_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign idle    = (state_reg == IDLE);
  assign code    = code_reg;
  assign uniform = uniform_reg;
  assign done    = done_reg;

endmodule

// File: rtl/lbp_code_encoder.sv
// LBP code encoder: thresholds 8 neighbours against the centre pixel, flags
// uniform patterns; LBP_ROT_INV_EN selects the rotation-invariant output path.
module lbp_code_encoder
  import lbp_pkg::*;
#(
  parameter logic [7:0] T = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] mid_i,
  input  logic [7:0] S1_i,
  input  logic [7:0] S2_i,
  input  logic [7:0] S3_i,
  input  logic [7:0] S4_i,
  input  logic [7:0] S5_i,
  input  logic [7:0] S6_i,
  input  logic [7:0] S7_i,
  input  logic [7:0] S8_i,
  output logic       ready_o,
  output logic [7:0] code_o,
  output logic       uniform_o,
  output logic       overflow_o,
  output logic       done_o
);

  logic [7:0] s_arr [NEIGH];
  logic [8:0] thr;
  logic [7:0] raw_code;
  logic       raw_uniform;
  logic       accept;

  logic       s1_valid_reg;
  logic [7:0] s1_code_reg;
  logic       s1_uniform_reg;

  assign s_arr[0] = S1_i;
  assign s_arr[1] = S2_i;
  assign s_arr[2] = S3_i;
  assign s_arr[3] = S4_i;
  assign s_arr[4] = S5_i;
  assign s_arr[5] = S6_i;
  assign s_arr[6] = S7_i;
  assign s_arr[7] = S8_i;

  // 9-bit threshold: a saturated mid+T can never be reached by an 8-bit sample.
  assign thr = {1'b0, mid_i} + {1'b0, T};

  for (genvar gi = 0; gi < NEIGH; gi++) begin : g_cmp
    assign raw_code[gi] = ({1'b0, s_arr[gi]} >= thr);
  end

  assign raw_uniform = (lbp_transitions(raw_code) <= 4'd2);
  assign accept      = done_i && ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_code_reg    <= 8'd0;
      s1_uniform_reg <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_code_reg    <= raw_code;
        s1_uniform_reg <= raw_uniform;
      end
    end
  end

`ifdef LBP_ROT_INV_EN
  logic rot_idle;
  logic overflow_reg;

  lbp_min_rotator u_rot (
    .clk         (clk),
    .rst         (rst),
    .start       (s1_valid_reg),
    .raw_code    (s1_code_reg),
    .raw_uniform (s1_uniform_reg),
    .idle        (rot_idle),
    .code        (code_o),
    .uniform     (uniform_o),
    .done        (done_o)
  );

  // A sample sitting in stage 1 has not reached the rotator yet, so it still counts as busy.
  assign ready_o = rot_idle && !s1_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (done_i && !ready_o) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow_o = overflow_reg;
`else
  logic [7:0] code_reg;
  logic       uniform_reg;
  logic       done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg    <= 8'd0;
      uniform_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        code_reg    <= s1_code_reg;
        uniform_reg <= s1_uniform_reg;
      end
    end
  end

  assign ready_o    = 1'b1;
  assign overflow_o = 1'b0;
  assign code_o     = code_reg;
  assign uniform_o  = uniform_reg;
  assign done_o     = done_reg;
`endif

endmodule

// File: tb/tb_lbp_code_encoder.sv
// Randomized self-checking bench for lbp_code_encoder (T=0 and T=10 instances)
// against a behavioural LBP model; follows the LBP_ROT_INV_EN build setting.
module tb_lbp_code_encoder;

`ifdef LBP_ROT_INV_EN
  localparam bit ROT_EN = 1'b1;
  localparam int LAT    = 10;
`else
  localparam bit ROT_EN = 1'b0;
  localparam int LAT    = 2;
`endif

  typedef logic [7:0] pix_t [8];
  typedef struct {
    int due;
    int code0;
    int uni0;
    int code1;
    int uni1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  logic [7:0] mid_i;
  pix_t       s_i;
  logic       ready_o    [2];
  logic [7:0] code_o     [2];
  logic       uniform_o  [2];
  logic       overflow_o [2];
  logic       done_o     [2];

  always #5 clk = ~clk;

  lbp_code_encoder #(.T(8'd0)) dut0 (
    .clk(clk), .rst(rst), .done_i(done_i), .mid_i(mid_i),
    .S1_i(s_i[0]), .S2_i(s_i[1]), .S3_i(s_i[2]), .S4_i(s_i[3]),
    .S5_i(s_i[4]), .S6_i(s_i[5]), .S7_i(s_i[6]), .S8_i(s_i[7]),
    .ready_o(ready_o[0]), .code_o(code_o[0]), .uniform_o(uniform_o[0]),
    .overflow_o(overflow_o[0]), .done_o(done_o[0])
  );

  lbp_code_encoder #(.T(8'd10)) dut1 (
    .clk(clk), .rst(rst), .done_i(done_i), .mid_i(mid_i),
    .S1_i(s_i[0]), .S2_i(s_i[1]), .S3_i(s_i[2]), .S4_i(s_i[3]),
    .S5_i(s_i[4]), .S6_i(s_i[5]), .S7_i(s_i[6]), .S8_i(s_i[7]),
    .ready_o(ready_o[1]), .code_o(code_o[1]), .uniform_o(uniform_o[1]),
    .overflow_o(overflow_o[1]), .done_o(done_o[1])
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   next_free;
  int   ovf_exp;
  int   ovf_pend;
  int   last_code [2];
  int   last_uni  [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference: bit k set iff S_k >= mid + t, using unbounded integer arithmetic.
  function automatic int ref_code(input int mid, input pix_t s, input int t);
    int c = 0;
    for (int k = 0; k < 8; k++) if (int'(s[k]) >= mid + t) c += (1 << k);
    return c;
  endfunction

  function automatic int ref_uniform(input int c);
    int tr = 0;
    for (int k = 0; k < 8; k++) if (((c >> k) & 1) != ((c >> ((k + 1) % 8)) & 1)) tr++;
    return (tr <= 2) ? 1 : 0;
  endfunction

  function automatic int ref_min_rot(input int c);
    int best = c;
    for (int r = 1; r < 8; r++) begin
      int v = ((c >> r) | (c << (8 - r))) & 255;
      if (v < best) best = v;
    end
    return best;
  endfunction

  function automatic pix_t pix_from_code(input int c);
    pix_t p;
    for (int k = 0; k < 8; k++) p[k] = ((c >> k) & 1) ? 8'd200 : 8'd0;
    return p;
  endfunction

  // Advance one clock and compare every output against the model.
  task automatic step();
    int exp_done;
    @(posedge clk);
    #1;
    cyc++;
    if (ovf_pend != 0) ovf_exp = 1;
    ovf_pend = 0;
    exp_done = (exp_q.size() > 0 && exp_q[0].due == cyc) ? 1 : 0;
    if (exp_done != 0) begin
      last_code[0] = exp_q[0].code0;
      last_uni[0]  = exp_q[0].uni0;
      last_code[1] = exp_q[0].code1;
      last_uni[1]  = exp_q[0].uni1;
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("done%0d", i), int'(done_o[i]), exp_done);
      check($sformatf("code%0d", i), int'(code_o[i]), last_code[i]);
      check($sformatf("uniform%0d", i), int'(uniform_o[i]), last_uni[i]);
      check($sformatf("overflow%0d", i), int'(overflow_o[i]), ovf_exp);
    end
    if (exp_done != 0)
      $display("txn cycle %0d: code T0=%02h T10=%02h uniform %0d/%0d",
               cyc, code_o[0], code_o[1], uniform_o[0], uniform_o[1]);
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("latency", exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
  endtask

  // Present inputs for the current cycle; checks ready_o and books the result.
  task automatic drive(input logic d, input logic [7:0] mid, input pix_t s);
    int   exp_ready;
    exp_t e;
    done_i = d;
    mid_i  = mid;
    s_i    = s;
    exp_ready = (!ROT_EN || cyc >= next_free) ? 1 : 0;
    check("ready0", int'(ready_o[0]), exp_ready);
    check("ready1", int'(ready_o[1]), exp_ready);
    if (d) begin
      if (exp_ready != 0) begin
        e.due   = cyc + LAT;
        e.code0 = ref_code(int'(mid), s, 0);
        e.code1 = ref_code(int'(mid), s, 10);
        e.uni0  = ref_uniform(e.code0);
        e.uni1  = ref_uniform(e.code1);
        if (ROT_EN) begin
          e.code0   = ref_min_rot(e.code0);
          e.code1   = ref_min_rot(e.code1);
          next_free = cyc + 10;
        end
        exp_q.push_back(e);
      end else begin
        ovf_pend = 1;
      end
    end
    step();
  endtask

  task automatic idle(input int n);
    pix_t z;
    for (int k = 0; k < 8; k++) z[k] = 8'd0;
    repeat (n) drive(1'b0, 8'd0, z);
  endtask

  task automatic do_reset();
    done_i = 1'b0;
    rst    = 1'b1;
    #1;
    exp_q.delete();
    next_free = 0;
    ovf_exp   = 0;
    ovf_pend  = 0;
    for (int i = 0; i < 2; i++) begin
      last_code[i] = 0;
      last_uni[i]  = 0;
    end
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", int'(ready_o[i]), 1);
      check("rst_code", int'(code_o[i]), 0);
      check("rst_done", int'(done_o[i]), 0);
      check("rst_overflow", int'(overflow_o[i]), 0);
    end
  endtask

  initial begin
    pix_t p;
    rst    = 1'b0;
    done_i = 1'b0;
    mid_i  = 8'd0;
    for (int k = 0; k < 8; k++) s_i[k] = 8'd0;
    do_reset();

    // Mixed pattern: raw 0xD5 for T=0.
    p = '{8'd100, 8'd99, 8'd150, 8'd20, 8'd255, 8'd0, 8'd101, 8'd100};
    drive(1'b1, 8'd100, p);
    idle(LAT + 1);

    // Saturated threshold on the T=10 instance.
    for (int k = 0; k < 8; k++) p[k] = 8'd255;
    drive(1'b1, 8'd250, p);
    idle(LAT + 1);

    // Upper half set: 0xF0, rotation-invariant 0x0F.
    p = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd200, 8'd200, 8'd200, 8'd200};
    drive(1'b1, 8'd100, p);
    idle(LAT + 1);

    // Back-to-back samples.
    drive(1'b1, 8'd100, pix_from_code(8'h01));
    drive(1'b1, 8'd100, pix_from_code(8'h80));
    drive(1'b1, 8'd100, pix_from_code(8'hFF));
    idle(LAT + 12);

    // Second strobe 3 cycles after the first.
    drive(1'b1, 8'd100, pix_from_code(8'h3C));
    idle(2);
    drive(1'b1, 8'd100, pix_from_code(8'h81));
    idle(LAT + 12);

    // Reset 4 cycles after an accept.
    drive(1'b1, 8'd100, pix_from_code(8'h70));
    idle(3);
    do_reset();
    idle(LAT + 3);

    // Randomized traffic; overflow becomes sticky in the rotator build.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] mid;
      mid = ($urandom_range(0, 5) == 0) ? 8'(240 + $urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++)
        p[k] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'(int'(mid) + $urandom_range(0, 20) - 5);
      drive(1'($urandom_range(0, 1)), mid, p);
    end
    idle(LAT + 12);
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
